// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts ALU requests, drives an external combinational ALU
// from a one-stage exec register, and buffers results in a 3-entry response
// FIFO.
// Optional build macro: ALU_FWD_EN adds req_fwd, which substitutes the most
// recently buffered result for operand A.
//
// Handshakes (both ports): a transfer happens on a rising clk edge where the
// sender's valid and the receiver's ready are both high. req_ready depends on
// registered state only. rsp_result/rsp_flag stay stable while rsp_valid is
// high and the head has not been popped.
module alu_sequencer #(
  parameter int DEPTH = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [2:0]  req_op,
`ifdef ALU_FWD_EN
  input  logic        req_fwd,
`endif
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_ctrl,
  input  logic [31:0] alu_result,
  input  logic [2:0]  alu_flag,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [2:0]  rsp_flag,
  output logic [1:0]  rsp_count
);

  localparam logic [1:0] LAST_IDX = 2'(DEPTH - 1);

  // Exec stage register.
  logic        r_exec_valid;
  logic [31:0] r_exec_a;
  logic [31:0] r_exec_b;
  logic [2:0]  r_exec_op;

  // Response FIFO storage and pointers.
  logic [31:0] r_mem_result [DEPTH];
  logic [2:0]  r_mem_flag   [DEPTH];
  logic [1:0]  r_wr_ptr;
  logic [1:0]  r_rd_ptr;
  logic [1:0]  r_count;

  logic        w_accept;
  logic        w_push;
  logic        w_pop;
  logic [2:0]  w_credit_used;
  logic [31:0] w_alu_a;

  // Credit counts the request in exec plus every buffered entry. Because of
  // this, a push can never find the FIFO full.
  assign w_credit_used = {2'b00, r_exec_valid} + {1'b0, r_count};
  assign req_ready     = (w_credit_used < 3'd3);
  assign w_accept      = req_valid & req_ready;
  assign w_push        = r_exec_valid;
  assign w_pop         = (r_count != 2'd0) & rsp_ready;

`ifdef ALU_FWD_EN
  logic        r_exec_fwd;
  logic [31:0] r_last_result;

  // The forward mux sits in the exec stage, so a result pushed on the edge
  // that starts exec is already visible in r_last_result.
  assign w_alu_a = r_exec_fwd ? r_last_result : r_exec_a;

  // Track the most recent value pushed into the FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_result <= '0;
    end else if (w_push) begin
      r_last_result <= alu_result;
    end
  end

  // Exec register load. When exec ends without a new request, the forwarded
  // operand is frozen into r_exec_a so alu_a holds its last value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_exec_valid <= 1'b0;
      r_exec_a     <= '0;
      r_exec_b     <= '0;
      r_exec_op    <= '0;
      r_exec_fwd   <= 1'b0;
    end else if (w_accept) begin
      r_exec_valid <= 1'b1;
      r_exec_a     <= req_a;
      r_exec_b     <= req_b;
      r_exec_op    <= req_op;
      r_exec_fwd   <= req_fwd;
    end else begin
      r_exec_valid <= 1'b0;
      if (r_exec_valid) begin
        r_exec_a   <= w_alu_a;
        r_exec_fwd <= 1'b0;
      end
    end
  end
`else
  assign w_alu_a = r_exec_a;

  // Exec register load. The operands hold while no request is in exec.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_exec_valid <= 1'b0;
      r_exec_a     <= '0;
      r_exec_b     <= '0;
      r_exec_op    <= '0;
    end else if (w_accept) begin
      r_exec_valid <= 1'b1;
      r_exec_a     <= req_a;
      r_exec_b     <= req_b;
      r_exec_op    <= req_op;
    end else begin
      r_exec_valid <= 1'b0;
    end
  end
`endif

  assign alu_a    = w_alu_a;
  assign alu_b    = r_exec_b;
  assign alu_ctrl = r_exec_op;

  // Capture the ALU output at the end of every exec cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_result[i] <= '0;
        r_mem_flag[i]   <= '0;
      end
    end else if (w_push) begin
      r_mem_result[r_wr_ptr] <= alu_result;
      r_mem_flag[r_wr_ptr]   <= alu_flag;
    end
  end

  // Pointers wrap modulo DEPTH. Occupancy is unchanged on simultaneous
  // push and pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == LAST_IDX) ? 2'd0 : r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == LAST_IDX) ? 2'd0 : r_rd_ptr + 2'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rsp_valid  = (r_count != 2'd0);
  assign rsp_result = r_mem_result[r_rd_ptr];
  assign rsp_flag   = r_mem_flag[r_rd_ptr];
  assign rsp_count  = r_count;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: drives alu_sequencer with an attached behavioural ALU.
// The reference model tracks outstanding work as one in-exec slot plus a
// queue of expected responses.
module tb_alu_sequencer;

`ifdef ALU_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [2:0]  req_op = '0;
  logic        req_fwd = 1'b0;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic [2:0]  alu_flag;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic [2:0]  rsp_flag;
  logic [1:0]  rsp_count;

  int n_cmp = 0;
  int n_bad = 0;

  alu_sequencer #(.DEPTH(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
`ifdef ALU_FWD_EN
    .req_fwd    (req_fwd),
`endif
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_flag   (alu_flag),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_flag   (rsp_flag),
    .rsp_count  (rsp_count)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- behavioural ALU: returns {flag, result} ----------------
  function automatic logic [34:0] alu_fn(logic [31:0] a, logic [31:0] b, logic [2:0] op);
    logic [31:0] r;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: r = a << b[4:0];
      default: r = a >> b[4:0];
    endcase
    return {(r == 32'd0), r[31], ^r, r};
  endfunction

  assign {alu_flag, alu_result} = alu_fn(alu_a, alu_b, alu_ctrl);

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [34:0] exp_q[$];
  logic [31:0] pop_log[$];
  bit          ex_pend = 1'b0;
  bit          ex_fwd = 1'b0;
  logic [31:0] ex_a = '0;
  logic [31:0] ex_b = '0;
  logic [2:0]  ex_op = '0;
  logic [31:0] m_last = '0;
  logic [31:0] hold_a = '0;
  logic [31:0] hold_b = '0;
  logic [2:0]  hold_op = '0;
  int          n_acc = 0;
  int          n_pop = 0;

  // Sampled on the falling edge: check visible state, then apply the events
  // that the next rising edge will perform.
  always @(negedge clk) begin : monitor
    logic [31:0] ea;
    logic [34:0] r;
    if (reset) begin
      exp_q.delete();
      ex_pend = 1'b0;
      ex_fwd  = 1'b0;
      m_last  = '0;
      hold_a  = '0;
      hold_b  = '0;
      hold_op = '0;
    end else begin
      check("rsp_count", 64'(rsp_count), 64'(exp_q.size()));
      check("rsp_valid", 64'(rsp_valid), 64'(exp_q.size() != 0));
      check("req_ready", 64'(req_ready), 64'((exp_q.size() + int'(ex_pend)) < 3));
      ea = (FWD && ex_fwd) ? m_last : ex_a;
      if (ex_pend) begin
        hold_a  = ea;
        hold_b  = ex_b;
        hold_op = ex_op;
      end
      check("alu_a", 64'(alu_a), 64'(hold_a));
      check("alu_b", 64'(alu_b), 64'(hold_b));
      check("alu_ctrl", 64'(alu_ctrl), 64'(hold_op));
      if (exp_q.size() != 0) begin
        check("rsp_head", 64'({rsp_flag, rsp_result}), 64'(exp_q[0]));
      end
      if (rsp_ready && exp_q.size() != 0) begin
        r = exp_q.pop_front();
        pop_log.push_back(r[31:0]);
        n_pop++;
      end
      if (ex_pend) begin
        r = alu_fn(ea, ex_b, ex_op);
        exp_q.push_back(r);
        m_last = r[31:0];
      end
      if (req_valid && req_ready) begin
        ex_pend = 1'b1;
        ex_a    = req_a;
        ex_b    = req_b;
        ex_op   = req_op;
        ex_fwd  = req_fwd;
        n_acc++;
      end else begin
        ex_pend = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op, input logic fwd);
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    req_op    = op;
    req_fwd   = fwd;
  endtask

  task automatic drain(input string tag);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 10 && rsp_count != 2'd0; k++) step();
    step();
    check(tag, 64'(rsp_count), 64'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int a0;
    int p0;

    // Reset for 2 cycles, then check reset state.
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_count", 64'(rsp_count), 64'd0);
    check("rst_alu_a", 64'(alu_a), 64'd0);
    check("rst_alu_b", 64'(alu_b), 64'd0);
    check("rst_alu_ctrl", 64'(alu_ctrl), 64'd0);
    check("rst_rsp_data", 64'({rsp_flag, rsp_result}), 64'd0);

    // Single ADD request and its latency.
    rsp_ready = 1'b0;
    drive_req(32'h0020_0476, 32'hFFFF_FFFC, 3'd0, 1'b0);
    step();
    req_valid = 1'b0;
    check("single_alu_a", 64'(alu_a), 64'h0020_0476);
    check("single_alu_b", 64'(alu_b), 64'hFFFF_FFFC);
    check("single_early_valid", 64'(rsp_valid), 64'd0);
    step();
    check("single_rsp_valid", 64'(rsp_valid), 64'd1);
    check("single_rsp_result", 64'(rsp_result), 64'h0020_0472);
    drain("single_drain");

    // Backpressure: 4 offered with rsp_ready low, only 3 fit.
    rsp_ready = 1'b0;
    a0 = n_acc;
    for (int i = 0; i < 4; i++) begin
      drive_req($urandom, $urandom, 3'($urandom_range(0, 7)), 1'b0);
      step();
    end
    req_valid = 1'b0;
    check("bp_accepted", 64'(n_acc - a0), 64'd3);
    check("bp_req_ready", 64'(req_ready), 64'd0);
    check("bp_full", 64'(rsp_count), 64'd3);
    drain("bp_drain");
    check("bp_ready_back", 64'(req_ready), 64'd1);

    // Throughput: 8 back-to-back with rsp_ready high.
    rsp_ready = 1'b1;
    a0 = n_acc;
    p0 = n_pop;
    pop_log.delete();
    for (int i = 0; i < 8; i++) begin
      drive_req(32'(i), 32'd1, 3'd0, 1'b0);
      step();
    end
    req_valid = 1'b0;
    check("tp_accepted", 64'(n_acc - a0), 64'd8);
    step();
    step();
    check("tp_popped", 64'(n_pop - p0), 64'd8);
    check("tp_log_size", 64'(pop_log.size()), 64'd8);
    for (int i = 0; i < 8 && i < pop_log.size(); i++) begin
      check("tp_order", 64'(pop_log[i]), 64'(i + 1));
    end

    // Reset with two requests outstanding; a request during reset is ignored.
    rsp_ready = 1'b0;
    drive_req(32'h1111_1111, 32'h2222_2222, 3'd0, 1'b0);
    step();
    drive_req(32'h3333_3333, 32'h4444_4444, 3'd4, 1'b0);
    step();
    reset = 1'b1;
    drive_req(32'h5555_5555, 32'h6666_6666, 3'd0, 1'b0);
    step();
    reset = 1'b0;
    req_valid = 1'b0;
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_rsp_count", 64'(rsp_count), 64'd0);
    check("mid_rst_req_ready", 64'(req_ready), 64'd1);
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) step();
    check("mid_rst_no_stale", 64'(rsp_valid), 64'd0);

`ifdef ALU_FWD_EN
    // Forwarding: 5+3, then last_result+1.
    rsp_ready = 1'b1;
    pop_log.delete();
    drive_req(32'd5, 32'd3, 3'd0, 1'b0);
    step();
    drive_req($urandom, 32'd1, 3'd0, 1'b1);
    step();
    req_valid = 1'b0;
    req_fwd = 1'b0;
    for (int k = 0; k < 3; k++) step();
    check("fwd_count", 64'(pop_log.size()), 64'd2);
    if (pop_log.size() == 2) begin
      check("fwd_first", 64'(pop_log[0]), 64'd8);
      check("fwd_second", 64'(pop_log[1]), 64'd9);
    end
`endif

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 400; c++) begin
      reset     = ($urandom_range(0, 149) == 0);
      req_valid = ($urandom_range(0, 3) != 0);
      req_a     = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 15));
      req_b     = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 15));
      req_op    = 3'($urandom_range(0, 7));
      req_fwd   = 1'($urandom_range(0, 1));
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    reset = 1'b0;
    req_fwd = 1'b0;
    drain("rand_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
